ifetch_buffer: RTL and testbench

In-order instruction fetch buffer between the PC/next-address stage and decode. Takes the fetch stage's current PC, issues requests to instruction memory over a req/gnt + rvalid interface, and stores up to DEPTH {pc, instr} pairs. Delivers them to decode over valid/ready. Stalls the PC when no slot is free, and discards all buffered and in-flight fetches on a taken branch.

---
 rtl/ifetch_buffer_pkg.sv | 18 +
 rtl/ifb_entry_ram.sv | 50 +++++
 rtl/ifetch_buffer.sv | 107 ++++++++++
 tb/tb_ifetch_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_buffer_pkg.sv
// Shared defaults and types for the instruction fetch buffer.
package ifetch_buffer_pkg;

    localparam int IFB_DEPTH = 4;
    localparam int IFB_AW    = 32;
    localparam int IFB_DW    = 32;

    typedef struct packed {
        logic [IFB_AW-1:0] pc;
        logic [IFB_DW-1:0] instr;
        logic              filled;
    } ifb_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ifb_entry_ram.sv
// DEPTH-entry {pc, instr, filled} store with independent allocate, fill and read ports.
module ifb_entry_ram
    import ifetch_buffer_pkg::*;
#(
    parameter int DEPTH = IFB_DEPTH,
    parameter int AW    = IFB_AW,
    parameter int DW    = IFB_DW,
    localparam int PW   = ptr_width(DEPTH)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_all,
    input  logic          alloc_en,
    input  logic [PW-1:0] alloc_idx,
    input  logic [AW-1:0] alloc_pc,
    input  logic          fill_en,
    input  logic [PW-1:0] fill_idx,
    input  logic [DW-1:0] fill_instr,
    input  logic          pop_en,
    input  logic [PW-1:0] rd_idx,
    output logic [AW-1:0] rd_pc,
    output logic [DW-1:0] rd_instr,
    output logic          rd_filled
);

    logic [AW-1:0]    pc_mem    [DEPTH];
    logic [DW-1:0]    instr_mem [DEPTH];
    logic [DEPTH-1:0] filled;

    // Popped entries are cleared so a wrapped read pointer never sees stale data.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            filled <= '0;
        end else begin
            if (pop_en)   filled[rd_idx]    <= 1'b0;
            if (alloc_en) filled[alloc_idx] <= 1'b0;
            if (fill_en)  filled[fill_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) pc_mem[alloc_idx]   <= alloc_pc;
        if (fill_en)  instr_mem[fill_idx] <= fill_instr;
    end

    assign rd_pc     = pc_mem[rd_idx];
    assign rd_instr  = instr_mem[rd_idx];
    assign rd_filled = filled[rd_idx];

endmodule

// File: rtl/ifetch_buffer.sv
// In-order fetch buffer: issues imem requests for the fetch PC, holds {pc, instr}
// pairs until decode takes them, and discards stale responses after a taken branch.
module ifetch_buffer
    import ifetch_buffer_pkg::*;
#(
    parameter int DEPTH = IFB_DEPTH,
    parameter int AW    = IFB_AW,
    parameter int DW    = IFB_DW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_valid,
    input  logic          flush,
    output logic          pc_stall,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [DW-1:0] id_instr,
    output logic [AW-1:0] id_pc,
    output logic          err
);

    localparam int PW  = ptr_width(DEPTH);
    localparam int CW  = PW + 1;
    localparam int DCW = PW + 4;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]  wr_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0]  count, pend_cnt;
    logic [DCW-1:0] drop_cnt, drop_sum, drop_flush;
    logic           alloc, fill, pop, rd_filled, drop_rsp, spurious;

    assign imem_req  = pc_valid & ~flush & (count != FULL);
    assign imem_addr = pc_in;
    assign alloc     = imem_req & imem_gnt;
    assign pc_stall  = pc_valid & ~flush & ~alloc;
    assign id_valid  = rd_filled & ~flush;
    assign pop       = id_valid & id_ready;

    assign drop_rsp  = imem_rvalid & (drop_cnt != '0);
    assign spurious  = imem_rvalid & (drop_cnt == '0) & (pend_cnt == '0);
    assign fill      = imem_rvalid & (drop_cnt == '0) & (pend_cnt != '0) & ~flush;

    // Responses still owed after a flush: earlier drops plus unfilled entries, less
    // whichever response is arriving in the flush cycle itself.
    always_comb begin
        drop_sum   = drop_cnt + DCW'(pend_cnt);
        drop_flush = drop_sum;
        if (imem_rvalid && (drop_sum != '0)) drop_flush = drop_sum - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
            drop_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (spurious) err <= 1'b1;
            if (flush) begin
                wr_ptr   <= '0;
                fill_ptr <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                pend_cnt <= '0;
                drop_cnt <= drop_flush;
            end else begin
                if (alloc)    wr_ptr   <= wr_ptr + 1'b1;
                if (fill)     fill_ptr <= fill_ptr + 1'b1;
                if (pop)      rd_ptr   <= rd_ptr + 1'b1;
                if (drop_rsp) drop_cnt <= drop_cnt - 1'b1;
                count    <= count + CW'(alloc) - CW'(pop);
                pend_cnt <= pend_cnt + CW'(alloc) - CW'(fill);
            end
        end
    end

    ifb_entry_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .clear_all  (flush),
        .alloc_en   (alloc),
        .alloc_idx  (wr_ptr),
        .alloc_pc   (pc_in),
        .fill_en    (fill),
        .fill_idx   (fill_ptr),
        .fill_instr (imem_rdata),
        .pop_en     (pop),
        .rd_idx     (rd_ptr),
        .rd_pc      (id_pc),
        .rd_instr   (id_instr),
        .rd_filled  (rd_filled)
    );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: memory model with programmable latency,
// in-order scoreboard of {pc, instr}, handshake vector table and corner sequences.
module tb_ifetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, pc_valid, flush, pc_stall, imem_req, imem_gnt, imem_rvalid;
    logic        id_valid, id_ready, err;
    logic [31:0] pc_in, imem_addr, imem_rdata, id_instr, id_pc;

    always #5 clk = ~clk;

    ifetch_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .err         (err)
    );

    typedef struct { int unsigned due; logic [31:0] data; } mem_rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct {
        bit full; bit pv; bit fl; bit gnt;
        bit exp_req; bit exp_stall; bit exp_idv;
    } vec_t;

    mem_rsp_t    mem_q[$];
    exp_t        exp_q[$];
    vec_t        vecs[$];
    int          checks = 0, failures = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int          grants = 0, deliveries = 0;
    bit          spur = 0;
    bit          last_req, last_pop, last_rv, last_idv, last_stall, stall_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic add_vec(input bit full, input bit pv, input bit fl, input bit gnt,
                           input bit er, input bit es, input bit ei);
        vec_t v;
        v.full = full; v.pv = pv; v.fl = fl; v.gnt = gnt;
        v.exp_req = er; v.exp_stall = es; v.exp_idv = ei;
        vecs.push_back(v);
    endtask

    // One clock cycle, entered and left at the falling edge with inputs already set.
    task automatic cycle();
        exp_t     e;
        mem_rsp_t m;
        bit       acc;
        if (spur) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1; imem_rdata = mem_q[0].data;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = '0;
        end
        #1;
        acc        = imem_req && imem_gnt;
        last_req   = imem_req;
        last_pop   = id_valid && id_ready;
        last_rv    = imem_rvalid;
        last_idv   = id_valid;
        last_stall = pc_stall;
        if (pc_stall) stall_seen = 1'b1;
        if (imem_rvalid && !spur) void'(mem_q.pop_front());
        if (flush) exp_q.delete();
        if (acc) begin
            grants++;
            m.due = cyc + lat; m.data = imem_addr + 32'h1000;
            mem_q.push_back(m);
            e.pc = imem_addr; e.instr = imem_addr + 32'h1000;
            exp_q.push_back(e);
        end
        if (id_valid && id_ready) begin
            deliveries++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_delivery: got pc 0x%0h, expected no delivery", id_pc);
            end else begin
                e = exp_q.pop_front();
                check("deliver_pc", id_pc, e.pc);
                check("deliver_instr", id_instr, e.instr);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (acc) pc_in = pc_in + 32'd4;
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; spur = 1'b0; pc_in = '0;
        mem_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        pc_valid = 1'b0; flush = 1'b0; id_ready = 1'b1;
        while ((exp_q.size() > 0 || mem_q.size() > 0) && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || mem_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d deliveries outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), n);
        end
        #1;
        check({name, "_idle_id_valid"}, id_valid, 0);
        @(negedge clk);
    endtask

    // Combinational handshake vectors; inputs are removed before the next edge.
    task automatic run_vecs(input bit full);
        logic [31:0] saved_pc = pc_in;
        foreach (vecs[i]) begin
            if (vecs[i].full == full) begin
                imem_rvalid = 1'b0;
                pc_valid = vecs[i].pv; flush = vecs[i].fl; imem_gnt = vecs[i].gnt;
                pc_in = 32'h100 + 32'(i) * 32'd4;
                #1;
                check($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
                check($sformatf("vec%0d_stall", i), pc_stall, vecs[i].exp_stall);
                check($sformatf("vec%0d_idv", i), id_valid, vecs[i].exp_idv);
                check($sformatf("vec%0d_addr", i), imem_addr, 32'h100 + 32'(i) * 32'd4);
                pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
                @(negedge clk);
            end
        end
        pc_in = saved_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //       full pv fl gnt  req stall idv
        add_vec(0, 1, 0, 1,   1, 0, 0);
        add_vec(0, 1, 0, 0,   1, 1, 0);
        add_vec(0, 0, 0, 1,   0, 0, 0);
        add_vec(0, 1, 1, 1,   0, 0, 0);
        add_vec(0, 0, 1, 0,   0, 0, 0);
        add_vec(1, 1, 0, 1,   0, 1, 1);
        add_vec(1, 1, 0, 0,   0, 1, 1);
        add_vec(1, 0, 0, 0,   0, 0, 1);
        add_vec(1, 1, 1, 1,   0, 0, 0);

        // Reset state and empty-buffer handshake
        do_reset();
        #1;
        check("rst_id_valid", id_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_stall", pc_stall, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        run_vecs(0);

        // Streaming with a one-cycle memory
        lat = 1; pc_in = 0; pc_valid = 1; imem_gnt = 1; id_ready = 1;
        stall_seen = 0; deliveries = 0;
        repeat (20) cycle();
        check("stream_no_stall", stall_seen, 0);
        check("stream_deliveries", deliveries, 18);
        drain("stream");
        check("stream_err", err, 0);

        // Fill to full with decode blocked
        do_reset();
        lat = 1; pc_in = 0; pc_valid = 1; imem_gnt = 1; id_ready = 0; grants = 0;
        repeat (8) cycle();
        check("full_grants", grants, DEPTH);
        #1;
        check("full_stall", pc_stall, 1);
        check("full_req", imem_req, 0);
        check("full_head_pc", id_pc, 32'h0);
        pc_valid = 0;
        @(negedge clk);
        run_vecs(1);
        pc_valid = 1; imem_gnt = 1; id_ready = 1;
        cycle();
        check("pop_cycle_pop", last_pop, 1);
        check("pop_cycle_no_bypass", last_req, 0);
        cycle();
        check("req_after_pop", last_req, 1);
        drain("full");

        // Flush with responses in flight on a three-cycle memory
        do_reset();
        lat = 3; pc_in = 0; pc_valid = 1; imem_gnt = 1; id_ready = 0;
        repeat (4) cycle();
        flush = 1;
        cycle();
        check("flush_id_valid", last_idv, 0);
        check("flush_req", last_req, 0);
        check("flush_rvalid", last_rv, 1);
        flush = 0; pc_in = 32'h40; id_ready = 1; deliveries = 0;
        repeat (3) cycle();
        drain("flush");
        check("flush_deliveries", deliveries, 3);
        check("flush_err", err, 0);

        // Grant, fill and pop together at DEPTH-1
        do_reset();
        lat = 1; pc_in = 0; pc_valid = 1; imem_gnt = 1; id_ready = 0;
        repeat (3) cycle();
        id_ready = 1;
        cycle();
        check("tri_req", last_req, 1);
        check("tri_rvalid", last_rv, 1);
        check("tri_pop", last_pop, 1);
        id_ready = 0;
        cycle();
        check("tri_next_req", last_req, 1);
        cycle();
        check("tri_full_req", last_req, 0);
        check("tri_full_stall", last_stall, 1);
        drain("tri");
        check("tri_err", err, 0);

        // Spurious response
        do_reset();
        spur = 1;
        cycle();
        spur = 0;
        repeat (3) cycle();
        check("spur_err_sticky", err, 1);
        check("spur_id_valid", last_idv, 0);
        do_reset();
        #1;
        check("spur_err_reset", err, 0);
        @(negedge clk);

        // Reset in the middle of operation
        do_reset();
        lat = 1; pc_in = 0; pc_valid = 1; imem_gnt = 1; id_ready = 0;
        repeat (4) cycle();
        check("mid_pre_idv", last_idv, 1);
        do_reset();
        #1;
        check("mid_id_valid", id_valid, 0);
        check("mid_stall", pc_stall, 0);
        @(negedge clk);
        pc_valid = 1; imem_gnt = 1; grants = 0;
        repeat (6) cycle();
        check("mid_regrants", grants, DEPTH);
        drain("mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
